result_hex_tx: RTL and testbench

Formats a completed ALU result as ASCII hex and streams it byte-by-byte to the UART transmitter. It sits downstream of the divider/ALU in the UART hex calculator. It captures the 32-bit result on the `alu_done` pulse and emits 8 uppercase hex digits, MSB first, then CR LF. Each byte goes out through a start/busy handshake with `uart_tx`.

---
 rtl/result_hex_tx.sv | 79 +++++++
 tb/tb_result_hex_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/result_hex_tx.sv
// result_hex_tx: formats a 32-bit ALU result as uppercase ASCII hex plus CR LF and streams it to uart_tx
module result_hex_tx #(
  parameter bit SEP_EN = 1'b0
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        alu_done,
  input  logic [31:0] result,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        fmt_busy,
  output logic        fmt_done,
  output logic        ovf
);
  typedef enum logic [2:0] {IDLE, LOAD, START, ACK, WAIT, DONE} state_t;
  localparam logic [3:0] LAST = SEP_EN ? 4'd10 : 4'd9;
  state_t      state;
  logic [31:0] sreg;
  logic [3:0]  cnt;
  logic [3:0]  nib;
  logic        is_sep, is_cr, is_lf, is_dig;
  logic [7:0]  hex, chr;
  always_comb begin
    nib    = sreg[31:28];
    is_sep = SEP_EN && cnt == 4'd4;
    is_cr  = cnt == LAST - 4'd1;
    is_lf  = cnt == LAST;
    is_dig = !(is_sep || is_cr || is_lf);
    hex    = (nib < 4'd10 ? 8'h30 : 8'h37) + {4'h0, nib};
    chr    = is_sep ? 8'h20 : is_cr ? 8'h0d : is_lf ? 8'h0a : hex;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      fmt_busy <= 1'b0;
      fmt_done <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      ovf      <= alu_done && state != IDLE;
      tx_start <= 1'b0;
      fmt_done <= 1'b0;
      case (state)
        IDLE: if (alu_done) begin
          sreg     <= result;
          cnt      <= '0;
          fmt_busy <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          tx_data <= chr;
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: state <= ACK;
        ACK:   state <= WAIT;
        WAIT: if (!tx_busy) begin
          cnt <= cnt + 4'd1;
          if (is_dig) sreg <= sreg << 4;
          if (is_lf) begin
            fmt_done <= 1'b1;
            state    <= DONE;
          end else state <= LOAD;
        end
        DONE: begin
          fmt_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_hex_tx.sv
// tb_result_hex_tx: scoreboard bench for result_hex_tx with both separator settings
module tb_result_hex_tx;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] result;
  logic        ad0, ad1, force0;
  logic        busy0, busy1, start0, start1, fb0, fb1, done0, done1, ovf0, ovf1;
  logic [7:0]  data0, data1;
  int          bc0, bc1;
  int          errors = 0, checks = 0;
  int          starts0 = 0, starts1 = 0, dones0 = 0, dones1 = 0, ovfs0 = 0, ovfs1 = 0;
  logic [7:0]  q0[$], q1[$];
  always #5 clk = ~clk;
  result_hex_tx #(.SEP_EN(1'b0)) dut0 (
    .clk(clk), .n_rst(n_rst), .alu_done(ad0), .result(result), .tx_busy(busy0),
    .tx_start(start0), .tx_data(data0), .fmt_busy(fb0), .fmt_done(done0), .ovf(ovf0)
  );
  result_hex_tx #(.SEP_EN(1'b1)) dut1 (
    .clk(clk), .n_rst(n_rst), .alu_done(ad1), .result(result), .tx_busy(busy1),
    .tx_start(start1), .tx_data(data1), .fmt_busy(fb1), .fmt_done(done1), .ovf(ovf1)
  );
  assign busy0 = bc0 > 0 || force0;
  assign busy1 = bc1 > 0;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bc0 <= 0;
      bc1 <= 0;
    end else begin
      bc0 <= start0 ? 10 : bc0 > 0 ? bc0 - 1 : 0;
      bc1 <= start1 ? 10 : bc1 > 0 ? bc1 - 1 : 0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (n_rst) begin
      if (start0) begin
        starts0++;
        chk("start0_while_busy", busy0, 0);
        if (q0.size() == 0) chk("unexpected_byte0", data0, 32'hffff_ffff);
        else chk("tx_data0", data0, q0.pop_front());
      end
      if (start1) begin
        starts1++;
        chk("start1_while_busy", busy1, 0);
        if (q1.size() == 0) chk("unexpected_byte1", data1, 32'hffff_ffff);
        else chk("tx_data1", data1, q1.pop_front());
      end
      if (done0) dones0++;
      if (done1) dones1++;
      if (ovf0) ovfs0++;
      if (ovf1) ovfs1++;
    end
  end
  task automatic push0(input string s);
    for (int i = 0; i < s.len(); i++) q0.push_back(s[i]);
    q0.push_back(8'h0d);
    q0.push_back(8'h0a);
  endtask
  task automatic push1(input string s);
    for (int i = 0; i < s.len(); i++) q1.push_back(s[i]);
    q1.push_back(8'h0d);
    q1.push_back(8'h0a);
  endtask
  task automatic fire0(input logic [31:0] r);
    result = r;
    ad0 = 1'b1;
    @(negedge clk);
    ad0 = 1'b0;
    chk("fmt_busy0_rise", fb0, 1);
  endtask
  task automatic fire1(input logic [31:0] r);
    result = r;
    ad1 = 1'b1;
    @(negedge clk);
    ad1 = 1'b0;
    chk("fmt_busy1_rise", fb1, 1);
  endtask
  task automatic wait_done0();
    int i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done0) break;
    end
    if (i == 600) chk("done0_timeout", 0, 1);
    @(negedge clk);
    chk("fmt_busy0_fall", fb0, 0);
  endtask
  task automatic wait_done1();
    int i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done1) break;
    end
    if (i == 600) chk("done1_timeout", 0, 1);
    @(negedge clk);
    chk("fmt_busy1_fall", fb1, 0);
  endtask
  task automatic wait_starts0(input int target);
    int i;
    for (i = 0; i < 600 && starts0 < target; i++) @(negedge clk);
    if (starts0 < target) chk("starts0_timeout", starts0, target);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_tx_start"}, {start1, start0}, 0);
    chk({tag, "_tx_data"}, {data1, data0}, 0);
    chk({tag, "_fmt_busy"}, {fb1, fb0}, 0);
    chk({tag, "_fmt_done"}, {done1, done0}, 0);
    chk({tag, "_ovf"}, {ovf1, ovf0}, 0);
  endtask
  initial begin
    int s, d, o, i;
    n_rst = 1'b0;
    ad0 = 1'b0;
    ad1 = 1'b0;
    force0 = 1'b0;
    result = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);
    s = starts0;
    d = dones0;
    push0("0002000E");
    fire0(32'h0002000e);
    @(negedge clk);
    chk("first_start_latency", start0, 1);
    wait_done0();
    chk("t1_starts", starts0 - s, 10);
    chk("t1_dones", dones0 - d, 1);
    s = starts0;
    o = ovfs0;
    push0("FFFFFFFF");
    fire0(32'hffffffff);
    wait_done0();
    push0("00000000");
    fire0(32'h00000000);
    wait_done0();
    chk("t2_starts", starts0 - s, 20);
    chk("t2_no_ovf", ovfs0 - o, 0);
    s = starts1;
    push1("1234 ABCD");
    fire1(32'h1234abcd);
    wait_done1();
    chk("t3_starts", starts1 - s, 11);
    force0 = 1'b1;
    repeat (3) @(negedge clk);
    s = starts0;
    push0("0002000E");
    fire0(32'h0002000e);
    repeat (16) @(negedge clk);
    chk("t4_held_off", starts0 - s, 0);
    force0 = 1'b0;
    for (i = 0; i < 5; i++) begin
      @(negedge clk);
      if (start0) break;
    end
    chk("t4_start_after_release", i <= 2, 1);
    wait_done0();
    s = starts0;
    o = ovfs0;
    push0("0002000E");
    fire0(32'h0002000e);
    wait_starts0(s + 4);
    result = 32'hdeadbeef;
    ad0 = 1'b1;
    @(negedge clk);
    ad0 = 1'b0;
    chk("t5_ovf_pulse", ovf0, 1);
    wait_done0();
    chk("t5_ovf_count", ovfs0 - o, 1);
    chk("t5_starts", starts0 - s, 10);
    s = starts0;
    push0("0002000E");
    fire0(32'h0002000e);
    wait_starts0(s + 6);
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk_zero("midreset");
    q0.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    push0("00010001");
    fire0(32'h00010001);
    wait_done0();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("dut1_no_ovf", ovfs1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
